// File: rtl/logic_gate_acc_if.sv
// logic_gate_acc_if: operand stream in, reduced result stream out, both valid/ready.
interface logic_gate_acc_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [2:0]              op;
    logic                    acc_en;
    logic [WIDTH-1:0]        out_data;
    logic                    out_red;
    logic [CNT_W-1:0]        out_beats;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, in_last, op, acc_en, out_ready,
        input  in_ready, out_data, out_red, out_beats, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, op, acc_en, out_ready,
        output in_ready, out_data, out_red, out_beats, out_valid
    );
endinterface

// File: rtl/logic_gate_acc.sv
// logic_gate_acc: bitwise AND/OR/XOR (optionally inverted) across operand lanes,
// with a burst accumulate mode that folds several beats into one registered result.
module logic_gate_acc #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
) (
    input logic               clk,
    input logic               rst_n,
    logic_gate_acc_if.slave   bus
);
    typedef enum logic {IDLE, ACCUM} state_t;
    typedef enum logic [1:0] {B_AND, B_OR, B_XOR} base_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [2:0]       lop;
    logic [CNT_W-1:0] cnt;

    logic [2:0]       eop;
    base_t            base;
    logic             inv;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] pacc;
    logic [WIDTH-1:0] p;
    logic             red;
    logic [CNT_W-1:0] cnt_next;
    logic             fire;
    logic             start;
    logic             load;

    function automatic logic [WIDTH-1:0] combine(input base_t bs, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return bs == B_OR ? (x | y) : bs == B_XOR ? (x ^ y) : (x & y);
    endfunction

    // Inside a burst the op latched on the first beat governs every later beat.
    assign eop  = state == ACCUM ? lop : bus.op;
    assign base = (eop == 3'd1 || eop == 3'd4) ? B_OR : (eop == 3'd2 || eop == 3'd5) ? B_XOR : B_AND;
    assign inv  = eop == 3'd3 || eop == 3'd4 || eop == 3'd5;

    always_comb begin
        b = bus.in_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++)
            b = combine(base, b, bus.in_data[k*WIDTH +: WIDTH]);
    end

    assign pacc     = combine(base, acc, b);
    assign p        = state == ACCUM ? pacc : b;
    assign red      = inv ^ (base == B_OR ? |p : base == B_XOR ? ^p : &p);
    assign cnt_next = cnt == '1 ? cnt : cnt + CNT_W'(1);

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign fire  = bus.in_valid && bus.in_ready;
    assign start = state == IDLE && bus.acc_en && !bus.in_last;
    assign load  = fire && (state == ACCUM ? bus.in_last : !start);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            lop           <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_red   <= 1'b0;
            bus.out_beats <= '0;
        end else begin
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= inv ? ~p : p;
                bus.out_red   <= red;
                bus.out_beats <= state == ACCUM ? cnt_next : CNT_W'(1);
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (fire && start) begin
                state <= ACCUM;
                acc   <= b;
                lop   <= bus.op;
                cnt   <= CNT_W'(1);
            end else if (fire && state == ACCUM) begin
                if (bus.in_last) begin
                    state <= IDLE;
                end else begin
                    acc <= pacc;
                    cnt <= cnt_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_logic_gate_acc.sv
// tb_logic_gate_acc: directed vector table plus hand-written burst, backpressure and
// reset-abort sequences; a second instance with a 2-bit beat counter checks saturation.
module tb_logic_gate_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic_gate_acc_if #(.WIDTH(8), .NUM_IN(2), .CNT_W(8)) bus ();
    logic_gate_acc_if #(.WIDTH(8), .NUM_IN(2), .CNT_W(2)) bus2 ();

    logic_gate_acc #(.WIDTH(8), .NUM_IN(2), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic_gate_acc #(.WIDTH(8), .NUM_IN(2), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_data;
        logic       exp_red;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic acc, input logic last);
        bus.op       = op;
        bus.in_data  = {b, a};
        bus.acc_en   = acc;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
    endtask

    task automatic beat2(input logic [7:0] a, input logic [7:0] b, input logic last);
        bus2.op       = 3'd0;
        bus2.in_data  = {b, a};
        bus2.acc_en   = 1'b1;
        bus2.in_last  = last;
        bus2.in_valid = 1'b1;
    endtask

    initial begin
        vecs[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[1] = '{3'd5, 8'hAA, 8'h0F, 8'h5A, 1'b1};
        vecs[2] = '{3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b1};
        vecs[3] = '{3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0};
        vecs[4] = '{3'd3, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[5] = '{3'd4, 8'h00, 8'h00, 8'hFF, 1'b1};
        vecs[6] = '{3'd6, 8'hCC, 8'hAA, 8'h88, 1'b0};
        vecs[7] = '{3'd7, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        vecs[8] = '{3'd2, 8'h01, 8'h00, 8'h01, 1'b1};
        vecs[9] = '{3'd3, 8'h0F, 8'hFF, 8'hF0, 1'b1};

        bus.in_data = '0; bus.in_last = 1'b0; bus.acc_en = 1'b0; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.op = 3'd1;
        bus2.in_data = '0; bus2.in_last = 1'b0; bus2.acc_en = 1'b0; bus2.op = '0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;

        // Reset held with a valid beat pending.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_valid", 32'(bus.out_valid), 0);
            chk("rst_data", 32'(bus.out_data), 32'h00);
            chk("rst_beats", 32'(bus.out_beats), 0);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(bus.in_ready), 1);
        chk("rst_idle_valid", 32'(bus.out_valid), 0);

        // Single-beat vectors.
        foreach (vecs[i]) begin
            beat(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 1);
            chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_red", i), 32'(bus.out_red), 32'(vecs[i].exp_red));
            chk($sformatf("vec%0d_beats", i), 32'(bus.out_beats), 1);
            step();
            chk($sformatf("vec%0d_drop", i), 32'(bus.out_valid), 0);
        end

        // Accumulate burst with a bubble; op change mid-burst is ignored.
        beat(3'd1, 8'h01, 8'h02, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("acc_b1_valid", 32'(bus.out_valid), 0);
        step();
        chk("acc_bubble_valid", 32'(bus.out_valid), 0);
        beat(3'd2, 8'h04, 8'h00, 1'b0, 1'b0);
        step();
        chk("acc_b2_valid", 32'(bus.out_valid), 0);
        beat(3'd2, 8'h80, 8'h10, 1'b0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("acc_valid", 32'(bus.out_valid), 1);
        chk("acc_data", 32'(bus.out_data), 32'h97);
        chk("acc_red", 32'(bus.out_red), 1);
        chk("acc_beats", 32'(bus.out_beats), 3);
        step();
        chk("acc_drop", 32'(bus.out_valid), 0);

        // Saturating 2-bit counter over a 5-beat burst.
        for (int i = 0; i < 5; i++) begin
            beat2(8'hFF, 8'hFF, i == 4);
            step();
        end
        bus2.in_valid = 1'b0;
        chk("sat_valid", 32'(bus2.out_valid), 1);
        chk("sat_data", 32'(bus2.out_data), 32'hFF);
        chk("sat_beats", 32'(bus2.out_beats), 3);

        // Backpressure: result held, then released with a beat pending.
        bus.out_ready = 1'b0;
        beat(3'd0, 8'hF0, 8'h3C, 1'b0, 1'b0);
        step();
        chk("bp_first_valid", 32'(bus.out_valid), 1);
        chk("bp_first_data", 32'(bus.out_data), 32'h30);
        beat(3'd1, 8'h01, 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_ready_low", 32'(bus.in_ready), 0);
            step();
            chk("bp_hold_valid", 32'(bus.out_valid), 1);
            chk("bp_hold_data", 32'(bus.out_data), 32'h30);
            chk("bp_hold_red", 32'(bus.out_red), 0);
            chk("bp_hold_beats", 32'(bus.out_beats), 1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_ready_pass", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_new_valid", 32'(bus.out_valid), 1);
        chk("bp_new_data", 32'(bus.out_data), 32'h03);
        chk("bp_new_red", 32'(bus.out_red), 1);
        step();
        chk("bp_drop", 32'(bus.out_valid), 0);

        // Reset aborts a partial burst.
        beat(3'd1, 8'hF0, 8'h00, 1'b1, 1'b0);
        step();
        beat(3'd1, 8'h0F, 8'h00, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_valid", 32'(bus.out_valid), 0);
        beat(3'd0, 8'hFF, 8'h0F, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("abort_new_valid", 32'(bus.out_valid), 1);
        chk("abort_new_data", 32'(bus.out_data), 32'h0F);
        chk("abort_new_beats", 32'(bus.out_beats), 1);
        chk("abort_new_red", 32'(bus.out_red), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
